// File: rtl/data_ram_hs.sv
// Big-endian byte-addressed data RAM with valid/ready request/response handshake and WAIT_CYCLES wait states.
// Optional macro RAM_ERR_CNT_EN adds a saturating 8-bit err_count output.
module data_ram_hs #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
`ifdef RAM_ERR_CNT_EN
  output logic [7:0]        err_count,
`endif
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              se_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  // Contents survive rst_n; only power-up gives zeros.
  logic [7:0] mem [DEPTH] = '{default: 8'h00};

  logic [ADDR_W-1:0] a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       rd_data;
  logic              access;
  logic              wr_en;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign access    = (state == WAIT) && (cnt == 4'd0);
  assign wr_en     = access && rw_q && !err_q;

  assign a1 = addr_q + ADDR_W'(1);
  assign a2 = addr_q + ADDR_W'(2);
  assign a3 = addr_q + ADDR_W'(3);
  assign b0 = mem[addr_q];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    rd_data = 32'h0;
    case (size_q)
      2'b00:   rd_data = {{24{se_q & b0[7]}}, b0};
      2'b01:   rd_data = {{16{se_q & b0[7]}}, b0, b1};
      2'b10:   rd_data = {b0, b1, b2, b3};
      default: rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (size_q)
        2'b00: mem[addr_q] <= wdata_q[7:0];
        2'b01: begin
          mem[addr_q] <= wdata_q[15:8];
          mem[a1]     <= wdata_q[7:0];
        end
        2'b10: begin
          mem[addr_q] <= wdata_q[31:24];
          mem[a1]     <= wdata_q[23:16];
          mem[a2]     <= wdata_q[15:8];
          mem[a3]     <= wdata_q[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= 2'b00;
      se_q      <= 1'b0;
      wdata_q   <= 32'h0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rw_q    <= req_rw;
            addr_q  <= req_addr;
            size_q  <= req_size;
            se_q    <= req_se;
            wdata_q <= req_wdata;
            err_q   <= (req_size == 2'b11) ||
                       (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00);
            cnt     <= 4'(WAIT_CYCLES);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            rsp_rdata <= (err_q || rw_q) ? 32'h0 : rd_data;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= 8'd0;
    else if (access && err_q && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_data_ram_hs.sv
// Directed bench for data_ram_hs: a WAIT_CYCLES=2 instance driven from a vector table plus
// hand sequences for stall, mid-operation reset, and a WAIT_CYCLES=0 instance.
module tb_data_ram_hs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid2 = 1'b0, valid0 = 1'b0;
  logic        req_rw = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_se = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;

  logic        rdy2, rv2, err2, busy2;
  logic [31:0] rd2;
  logic        rdy0, rv0, err0, busy0;
  logic [31:0] rd0;
`ifdef RAM_ERR_CNT_EN
  logic [7:0]  ecnt2, ecnt0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit sel      = 1'b0;

  logic        m_ready, m_valid, m_err, m_busy;
  logic [31:0] m_rdata;
  assign m_ready = sel ? rdy0 : rdy2;
  assign m_valid = sel ? rv0  : rv2;
  assign m_err   = sel ? err0 : err2;
  assign m_busy  = sel ? busy0 : busy2;
  assign m_rdata = sel ? rd0  : rd2;

  always #5 clk = ~clk;

  data_ram_hs #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(valid2), .req_ready(rdy2), .req_rw(req_rw),
    .req_addr(req_addr), .req_size(req_size), .req_se(req_se), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(err2),
`ifdef RAM_ERR_CNT_EN
    .err_count(ecnt2),
`endif
    .busy(busy2));

  data_ram_hs #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(rdy0), .req_rw(req_rw),
    .req_addr(req_addr), .req_size(req_size), .req_se(req_se), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(err0),
`ifdef RAM_ERR_CNT_EN
    .err_count(ecnt0),
`endif
    .busy(busy0));

  typedef struct {
    string       name;
    logic        rw;
    logic [8:0]  addr;
    logic [1:0]  size;
    logic        se;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One full request/response transaction on the selected instance; lat counts edges after accept.
  task automatic applyStimulus(input bit s, input logic rw, input logic [8:0] addr,
                               input logic [1:0] size, input logic se, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat);
    sel       = s;
    req_rw    = rw;
    req_addr  = addr;
    req_size  = size;
    req_se    = se;
    req_wdata = wdata;
    #0;
    checkOutput("req_ready_before_accept", {31'b0, m_ready}, 32'd1);
    if (s) valid0 = 1'b1; else valid2 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    valid2 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!m_valid && lat < 40);
    if (!m_valid) lat = -1;
    rdata = m_rdata;
    err   = m_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_cleared", {31'b0, m_valid}, 32'd0);
    checkOutput("rsp_rdata_cleared", m_rdata, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    vecs[0]  = '{"wr_word_010",    1'b1, 9'h010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{"rd_word_010",    1'b0, 9'h010, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"rd_byte_010_se", 1'b0, 9'h010, 2'b00, 1'b1, 32'h0,        32'hFFFFFFDE, 1'b0};
    vecs[3]  = '{"rd_byte_013_ze", 1'b0, 9'h013, 2'b00, 1'b0, 32'h0,        32'h000000EF, 1'b0};
    vecs[4]  = '{"rd_half_012_se", 1'b0, 9'h012, 2'b01, 1'b1, 32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[5]  = '{"rd_half_012_ze", 1'b0, 9'h012, 2'b01, 1'b0, 32'h0,        32'h0000BEEF, 1'b0};
    vecs[6]  = '{"wr_half_021_mis",1'b1, 9'h021, 2'b01, 1'b0, 32'h00001234, 32'h00000000, 1'b1};
    vecs[7]  = '{"wr_word_022_mis",1'b1, 9'h022, 2'b10, 1'b0, 32'h11223344, 32'h00000000, 1'b1};
    vecs[8]  = '{"rd_byte_021",    1'b0, 9'h021, 2'b00, 1'b0, 32'h0,        32'h00000000, 1'b0};
    vecs[9]  = '{"rd_size11",      1'b0, 9'h000, 2'b11, 1'b0, 32'h0,        32'h00000000, 1'b1};
    vecs[10] = '{"wr_byte_1ff",    1'b1, 9'h1FF, 2'b00, 1'b0, 32'hFFFFFF80, 32'h00000000, 1'b0};
    vecs[11] = '{"rd_byte_1ff_se", 1'b0, 9'h1FF, 2'b00, 1'b1, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[12] = '{"rd_word_1fc",    1'b0, 9'h1FC, 2'b10, 1'b0, 32'h0,        32'h00000080, 1'b0};
    vecs[13] = '{"wr_half_030",    1'b1, 9'h030, 2'b01, 1'b0, 32'hABCD1234, 32'h00000000, 1'b0};
    vecs[14] = '{"rd_word_030",    1'b0, 9'h030, 2'b10, 1'b1, 32'h0,        32'h12340000, 1'b0};

    #12;
    checkOutput("reset_rsp_valid", {31'b0, rv2}, 32'd0);
    checkOutput("reset_rsp_rdata", rd2, 32'd0);
    checkOutput("reset_rsp_err",   {31'b0, err2}, 32'd0);
    checkOutput("reset_req_ready", {31'b0, rdy2}, 32'd1);
    checkOutput("reset_busy",      {31'b0, busy2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, vecs[i].rw, vecs[i].addr, vecs[i].size, vecs[i].se, vecs[i].wdata, rd, er, lat);
      checkOutput({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, "_err"}, {31'b0, er}, {31'b0, vecs[i].exp_err});
      checkOutput({vecs[i].name, "_latency"}, 32'(lat), 32'd3);
    end
`ifdef RAM_ERR_CNT_EN
    checkOutput("err_count_after_table", {24'b0, ecnt2}, 32'd3);
`endif

    // Stall: response held for 5 cycles while an intruding write request is offered.
    sel = 1'b0;
    req_rw = 1'b0; req_addr = 9'h010; req_size = 2'b10; req_se = 1'b0;
    valid2 = 1'b1;
    @(posedge clk); #1;
    valid2 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rv2 && lat < 40);
    checkOutput("stall_latency", 32'(lat), 32'd3);
    req_rw = 1'b1; req_wdata = 32'h55555555;
    valid2 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("stall_rsp_valid", {31'b0, rv2}, 32'd1);
      checkOutput("stall_rsp_rdata", rd2, 32'hDEADBEEF);
      checkOutput("stall_rsp_err",   {31'b0, err2}, 32'd0);
      checkOutput("stall_req_ready", {31'b0, rdy2}, 32'd0);
    end
    valid2 = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("stall_release_valid", {31'b0, rv2}, 32'd0);
    checkOutput("stall_release_ready", {31'b0, rdy2}, 32'd1);
    applyStimulus(1'b0, 1'b0, 9'h010, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checkOutput("ignored_write_rdata", rd, 32'hDEADBEEF);

    // Reset during WAIT of a store abandons it.
    req_rw = 1'b1; req_addr = 9'h040; req_size = 2'b10; req_wdata = 32'hCAFEF00D;
    valid2 = 1'b1;
    @(posedge clk); #1;
    valid2 = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre_reset_busy", {31'b0, busy2}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_rsp_valid", {31'b0, rv2}, 32'd0);
    checkOutput("midreset_req_ready", {31'b0, rdy2}, 32'd1);
    checkOutput("midreset_busy",      {31'b0, busy2}, 32'd0);
`ifdef RAM_ERR_CNT_EN
    checkOutput("midreset_err_count", {24'b0, ecnt2}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 9'h040, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checkOutput("abandoned_store_rdata", rd, 32'h00000000);
    applyStimulus(1'b0, 1'b0, 9'h010, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checkOutput("persisted_store_rdata", rd, 32'hDEADBEEF);

    // Zero-wait instance at the top byte address.
    applyStimulus(1'b1, 1'b1, 9'h1FF, 2'b00, 1'b0, 32'h000000A5, rd, er, lat);
    checkOutput("w0_wr_rdata",   rd, 32'h0);
    checkOutput("w0_wr_err",     {31'b0, er}, 32'd0);
    checkOutput("w0_wr_latency", 32'(lat), 32'd1);
    applyStimulus(1'b1, 1'b0, 9'h1FF, 2'b00, 1'b0, 32'h0, rd, er, lat);
    checkOutput("w0_rd_rdata",   rd, 32'h000000A5);
    checkOutput("w0_rd_err",     {31'b0, er}, 32'd0);
    checkOutput("w0_rd_latency", 32'(lat), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_ram_hs.md
Name: data_ram_hs

Overview:
Parametrised, big-endian, byte-addressed data memory with a valid/ready request/response handshake. It is the successor to the single-cycle combinational-read data RAM on the datapath's MEM stage. It adds configurable wait states, registered read data, misalignment/illegal-size error responses, and explicit store acknowledgement. The memory stalls the pipeline via req_ready/rsp_valid instead of assuming zero-latency access.

Parameters:
ADDR_W, 9, byte-address width; memory depth is 2**ADDR_W bytes.
WAIT_CYCLES, 1, extra cycles (0..15) between request acceptance and the access edge.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request; equals (state==IDLE).
req_rw  input  1  0 = read (load), 1 = write (store).
req_addr  input  ADDR_W  byte address.
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
req_se  input  1  sign-extend on byte/halfword reads.
req_wdata  input  32  store data, right-aligned.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_rdata  output  32  load result; 0 for writes and errors.
rsp_err  output  1  request was rejected (misaligned or reserved size).
busy  output  1  state != IDLE.

Behaviour:
- Storage: 2**ADDR_W x 8-bit, zero-initialised at time 0. rst_n does not clear it.
- Byte order is big-endian: Mem[A] is most significant. Halfword = {Mem[A],Mem[A+1]}; word = {Mem[A]..Mem[A+3]}.
- Reset (async, rst_n=0): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. req_ready=1 and busy=0 while in reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On req_valid && req_ready, latch rw/addr/size/se/wdata.
  - Load the counter with WAIT_CYCLES and go to WAIT.
  - Compute the error flag: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0.
- WAIT:
  - If counter != 0, decrement it and stay.
  - If counter == 0, this edge is the access edge:
    - No error, write: store bytes of the latched size (byte: wdata[7:0]; half: wdata[15:8],[7:0]; word: all four bytes, MSB first); rsp_rdata<=0; rsp_err<=0.
    - No error, read: rsp_rdata <= zero- or sign-extended data per se (se ignored for word); rsp_err<=0.
    - Error: no memory write; rsp_rdata<=0; rsp_err<=1.
    - In all cases rsp_valid<=1 and the FSM goes to RESP.
- Latency: request accepted at edge N; access and rsp_valid rising at edge N+1+WAIT_CYCLES.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err stay stable until rsp_ready=1.
  - On rsp_valid && rsp_ready, at that edge: rsp_valid<=0, rsp_err<=0, rsp_rdata<=0, state goes to IDLE.
  - req_ready=0 in RESP, so there is no same-cycle turnaround. Minimum spacing between accepts is WAIT_CYCLES+3 cycles.
- Request inputs are ignored outside IDLE.
- Aligned accesses never wrap past the top address. Byte access at 2**ADDR_W-1 is legal.
- Read of a location written by the immediately preceding request returns the new data.
- Reset mid-operation: a pending request is abandoned. If reset asserts before the access edge, memory is unmodified. Stores completed before reset persist.

Optional Feature:
RAM_ERR_CNT_EN
- Defined: adds output err_count (8 bits), reset to 0 by rst_n. Increments at each access edge with an error. Saturates at 255.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- WAIT_CYCLES=2. Word write 0xDEADBEEF @0x010, then word read @0x010 -> write response rdata=0, err=0. Read rsp_valid rises exactly 3 edges after accept; rdata=0xDEADBEEF.
- Byte read @0x010 with se=1 -> 0xFFFFFFDE. Byte read @0x013 with se=0 -> 0x000000EF. Half read @0x012 with se=1 -> 0xFFFFBEEF; with se=0 -> 0x0000BEEF.
- Half write 0x1234 @0x021, then word write @0x022 -> both err=1, rdata=0. Byte read @0x021 -> 0x00 (memory untouched). Size=11 read -> err=1. With RAM_ERR_CNT_EN, err_count=3.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rdata and err stable; req_ready=0; a new req_valid during this time is ignored (not accepted).
- Assert rst_n=0 during WAIT of a word write 0xCAFEF00D @0x040 -> rsp_valid=0 and state IDLE immediately. Subsequent word read @0x040 -> 0x00000000.
- WAIT_CYCLES=0 build: byte write 0xA5 @0x1FF, then byte read @0x1FF -> rsp_valid one edge after accept; rdata=0x000000A5, err=0.
